// File: rtl/operand_fetch.sv
// operand_fetch
//
// Purpose:
//   Operand-fetch stage in front of execute. It reads the register file
//   through two combinational read ports and bypasses a same-cycle writeback
//   onto either operand. A one-bit-per-register scoreboard holds back any
//   instruction whose sources, or whose destination, still have a write in
//   flight. Operands are registered into one output slot that is handed to
//   execute with a valid/ready handshake.
//
// Ports:
//   clk                    clock, all state changes on the rising edge
//   reset                  asynchronous active-high reset
//   in_valid / in_ready    handshake from decode (in_ready is combinational)
//   in_rs1, in_rs2         source register numbers
//   in_rd, in_rd_we        destination register number and its write enable
//   rf_rnum1, rf_rnum2     register-file read addresses (follow in_rs1/in_rs2)
//   rf_rdata1, rf_rdata2   register-file read data
//   wb_en, wb_reg, wb_data writeback port (also commits into the register file)
//   out_valid / out_ready  handshake toward execute
//   out_op1, out_op2       registered operands
//   out_rd, out_rd_we      registered destination and write enable

module operand_fetch #(
    parameter int DATA_W = 64,
    parameter int NREG   = 32,
    parameter int AW     = 5
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AW-1:0]     in_rs1,
    input  logic [AW-1:0]     in_rs2,
    input  logic [AW-1:0]     in_rd,
    input  logic              in_rd_we,

    output logic [AW-1:0]     rf_rnum1,
    output logic [AW-1:0]     rf_rnum2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,

    input  logic              wb_en,
    input  logic [AW-1:0]     wb_reg,
    input  logic [DATA_W-1:0] wb_data,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_op1,
    output logic [DATA_W-1:0] out_op2,
    output logic [AW-1:0]     out_rd,
    output logic              out_rd_we
);

    logic [NREG-1:0]   pending;
    logic [NREG-1:0]   pending_next;

    logic              wb_hit1;
    logic              wb_hit2;
    logic              wb_hit_rd;
    logic              src_hazard;
    logic              dst_hazard;
    logic              slot_free;
    logic              fire;
    logic [DATA_W-1:0] op1_sel;
    logic [DATA_W-1:0] op2_sel;

    assign rf_rnum1 = in_rs1;
    assign rf_rnum2 = in_rs2;

    // The register file only commits the writeback at the clock edge, so a
    // value being written this cycle must be forwarded here. A pending bit
    // being cleared by that same writeback is not a hazard.
    assign wb_hit1   = wb_en && (wb_reg == in_rs1);
    assign wb_hit2   = wb_en && (wb_reg == in_rs2);
    assign wb_hit_rd = wb_en && (wb_reg == in_rd);

    assign op1_sel = wb_hit1 ? wb_data : rf_rdata1;
    assign op2_sel = wb_hit2 ? wb_data : rf_rdata2;

    assign src_hazard = (pending[in_rs1] && !wb_hit1) ||
                        (pending[in_rs2] && !wb_hit2);
    assign dst_hazard = in_rd_we && pending[in_rd] && !wb_hit_rd;

    assign slot_free = !out_valid || out_ready;
    assign in_ready  = slot_free && !src_hazard && !dst_hazard;
    assign fire      = in_valid && in_ready;

    // Writeback clears first, then a firing instruction sets its destination,
    // so a set and a clear of the same register in one cycle leaves it set.
    always_comb begin
        pending_next = pending;
        if (wb_en) begin
            pending_next[wb_reg] = 1'b0;
        end
        if (fire && in_rd_we) begin
            pending_next[in_rd] = 1'b1;
        end
    end

    // Output slot and scoreboard. When the slot drains with nothing new
    // arriving only out_valid drops; the data registers keep their values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending   <= '0;
            out_valid <= 1'b0;
            out_op1   <= '0;
            out_op2   <= '0;
            out_rd    <= '0;
            out_rd_we <= 1'b0;
        end else begin
            pending <= pending_next;
            if (fire) begin
                out_valid <= 1'b1;
                out_op1   <= op1_sel;
                out_op2   <= op2_sel;
                out_rd    <= in_rd;
                out_rd_we <= in_rd_we;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch
//
// Purpose:
//   Self-checking bench for operand_fetch. A table of single-issue vectors
//   covers operand selection and bypass; hand-written sequences cover the
//   scoreboard stall/release, WAW set-wins, backpressure and async reset.
//   The register file is a static image driven combinationally from the
//   read addresses; writebacks only exercise the bypass path.

module tb_operand_fetch;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [4:0]  in_rd;
    logic        in_rd_we;
    logic [4:0]  rf_rnum1;
    logic [4:0]  rf_rnum2;
    logic [63:0] rf_rdata1;
    logic [63:0] rf_rdata2;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [63:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_op1;
    logic [63:0] out_op2;
    logic [4:0]  out_rd;
    logic        out_rd_we;

    logic [63:0] rf_mem [32];

    int total;
    int bad;

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_we;
        logic        wbe;
        logic [4:0]  wbr;
        logic [63:0] wbd;
        logic [63:0] exp_op1;
        logic [63:0] exp_op2;
    } vec_t;

    vec_t vecs [6];

    operand_fetch #(.DATA_W(64), .NREG(32), .AW(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_rd     (in_rd),
        .in_rd_we  (in_rd_we),
        .rf_rnum1  (rf_rnum1),
        .rf_rnum2  (rf_rnum2),
        .rf_rdata1 (rf_rdata1),
        .rf_rdata2 (rf_rdata2),
        .wb_en     (wb_en),
        .wb_reg    (wb_reg),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op1   (out_op1),
        .out_op2   (out_op2),
        .out_rd    (out_rd),
        .out_rd_we (out_rd_we)
    );

    assign rf_rdata1 = rf_mem[rf_rnum1];
    assign rf_rdata2 = rf_mem[rf_rnum2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic applyStimulus(input logic v, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic we, input logic wbe,
                                 input logic [4:0] wbr, input logic [63:0] wbd,
                                 input logic ordy);
        @(negedge clk);
        in_valid  = v;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_rd     = rd;
        in_rd_we  = we;
        wb_en     = wbe;
        wb_reg    = wbr;
        wb_data   = wbd;
        out_ready = ordy;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 32; i++) rf_mem[i] = 64'hCAFE_0000_0000_0000 | 64'(i);
        rf_mem[0]  = 64'h5;
        rf_mem[1]  = 64'h11;
        rf_mem[2]  = 64'h22;
        rf_mem[7]  = 64'h0;
        rf_mem[31] = 64'hF0F0_0000_0000_001F;

        vecs[0] = '{5'd1,  5'd2,  5'd3, 1'b0, 1'b0, 5'd0, 64'h0, 64'h11, 64'h22};
        vecs[1] = '{5'd0,  5'd31, 5'd9, 1'b0, 1'b0, 5'd0, 64'h0, 64'h5, 64'hF0F0_0000_0000_001F};
        vecs[2] = '{5'd7,  5'd7,  5'd7, 1'b0, 1'b1, 5'd7, 64'h5A5A, 64'h5A5A, 64'h5A5A};
        vecs[3] = '{5'd1,  5'd2,  5'd0, 1'b0, 1'b1, 5'd2, 64'h99, 64'h11, 64'h99};
        vecs[4] = '{5'd31, 5'd0,  5'd1, 1'b0, 1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF,
                    64'hF0F0_0000_0000_001F, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[5] = '{5'd2,  5'd1,  5'd4, 1'b0, 1'b1, 5'd9, 64'h77, 64'h22, 64'h11};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_rd     = '0;
        in_rd_we  = 1'b0;
        wb_en     = 1'b0;
        wb_reg    = '0;
        wb_data   = '0;
        out_ready = 1'b1;

        // Reset state, with an instruction offered to show fire is blocked
        @(negedge clk);
        in_valid = 1'b1;
        in_rd_we = 1'b1;
        in_rd    = 5'd6;
        stepEdge();
        checkOutput("reset out_valid", 64'(out_valid), 64'h0);
        checkOutput("reset out_op1", out_op1, 64'h0);
        checkOutput("reset out_op2", out_op2, 64'h0);
        checkOutput("reset out_rd", 64'(out_rd), 64'h0);
        checkOutput("reset out_rd_we", 64'(out_rd_we), 64'h0);
        checkOutput("reset pending", 64'(dut.pending), 64'h0);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b0;

        // Table of hazard-free single issues
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].rd_we,
                          vecs[i].wbe, vecs[i].wbr, vecs[i].wbd, 1'b1);
            checkOutput($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'h1);
            stepEdge();
            checkOutput($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'h1);
            checkOutput($sformatf("vec%0d out_op1", i), out_op1, vecs[i].exp_op1);
            checkOutput($sformatf("vec%0d out_op2", i), out_op2, vecs[i].exp_op2);
            checkOutput($sformatf("vec%0d out_rd", i), 64'(out_rd), 64'(vecs[i].rd));
            checkOutput($sformatf("vec%0d out_rd_we", i), 64'(out_rd_we), 64'(vecs[i].rd_we));
            checkOutput($sformatf("vec%0d pending", i), 64'(dut.pending), 64'h0);
        end

        // Independent issue that claims x3
        applyStimulus(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 5'd0, 64'h0, 1'b1);
        stepEdge();
        checkOutput("issue op1", out_op1, 64'h11);
        checkOutput("issue op2", out_op2, 64'h22);
        checkOutput("issue rd", 64'(out_rd), 64'h3);
        checkOutput("issue pending", 64'(dut.pending), 64'h8);

        // RAW on x3: stall two cycles, then release by writeback
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1'b1, 5'd3, 5'd1, 5'd4, 1'b0, 1'b0, 5'd0, 64'h0, 1'b1);
            checkOutput($sformatf("raw stall%0d in_ready", c), 64'(in_ready), 64'h0);
            stepEdge();
        end
        checkOutput("raw drained out_valid", 64'(out_valid), 64'h0);
        applyStimulus(1'b1, 5'd3, 5'd1, 5'd4, 1'b0, 1'b1, 5'd3, 64'hABCD, 1'b1);
        checkOutput("raw release in_ready", 64'(in_ready), 64'h1);
        stepEdge();
        checkOutput("raw out_valid", 64'(out_valid), 64'h1);
        checkOutput("raw out_op1", out_op1, 64'hABCD);
        checkOutput("raw out_op2", out_op2, 64'h11);
        checkOutput("raw pending", 64'(dut.pending), 64'h0);

        // WAW on x5 with a simultaneous clear: the set wins
        applyStimulus(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 5'd0, 64'h0, 1'b1);
        stepEdge();
        checkOutput("waw setup pending", 64'(dut.pending), 64'h20);
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 5'd0, 64'h0, 1'b1);
        checkOutput("waw blocked in_ready", 64'(in_ready), 64'h0);
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 5'd5, 64'h55, 1'b1);
        checkOutput("waw in_ready", 64'(in_ready), 64'h1);
        stepEdge();
        checkOutput("waw out_valid", 64'(out_valid), 64'h1);
        checkOutput("waw out_rd", 64'(out_rd), 64'h5);
        checkOutput("waw pending", 64'(dut.pending), 64'h20);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd5, 64'h55, 1'b1);
        stepEdge();
        checkOutput("waw clear pending", 64'(dut.pending), 64'h0);
        checkOutput("waw drained out_valid", 64'(out_valid), 64'h0);

        // Backpressure: slot held for three cycles, then the next one fires
        applyStimulus(1'b1, 5'd1, 5'd2, 5'd6, 1'b0, 1'b0, 5'd0, 64'h0, 1'b1);
        stepEdge();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, 5'd2, 5'd1, 5'd8, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0);
            checkOutput($sformatf("bp%0d in_ready", c), 64'(in_ready), 64'h0);
            stepEdge();
            checkOutput($sformatf("bp%0d out_valid", c), 64'(out_valid), 64'h1);
            checkOutput($sformatf("bp%0d out_op1", c), out_op1, 64'h11);
            checkOutput($sformatf("bp%0d out_op2", c), out_op2, 64'h22);
            checkOutput($sformatf("bp%0d out_rd", c), 64'(out_rd), 64'h6);
        end
        applyStimulus(1'b1, 5'd2, 5'd1, 5'd8, 1'b0, 1'b0, 5'd0, 64'h0, 1'b1);
        checkOutput("bp release in_ready", 64'(in_ready), 64'h1);
        stepEdge();
        checkOutput("bp new out_op1", out_op1, 64'h22);
        checkOutput("bp new out_op2", out_op2, 64'h11);
        checkOutput("bp new out_rd", 64'(out_rd), 64'h8);

        // Async reset mid-stream with x3 and x4 pending
        applyStimulus(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 5'd0, 64'h0, 1'b1);
        stepEdge();
        applyStimulus(1'b1, 5'd2, 5'd1, 5'd4, 1'b1, 1'b0, 5'd0, 64'h0, 1'b1);
        stepEdge();
        checkOutput("prereset pending", 64'(dut.pending), 64'h18);
        checkOutput("prereset out_valid", 64'(out_valid), 64'h1);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async reset out_valid", 64'(out_valid), 64'h0);
        checkOutput("async reset pending", 64'(dut.pending), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b1, 5'd2, 5'd1, 5'd3, 1'b1, 1'b0, 5'd0, 64'h0, 1'b1);
        checkOutput("post reset in_ready", 64'(in_ready), 64'h1);
        stepEdge();
        checkOutput("post reset out_op1", out_op1, 64'h22);
        checkOutput("post reset out_op2", out_op2, 64'h11);
        checkOutput("post reset pending", 64'(dut.pending), 64'h8);
        // Stale writeback to x4 from before reset changes nothing
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd4, 64'h44, 1'b1);
        stepEdge();
        checkOutput("stale wb pending", 64'(dut.pending), 64'h8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
